// File: rtl/ct_pkg.sv
// ct_pkg: shared types and helpers for the ct_* crossbar blocks.
// Holds the routing state encoding and a constant-safe clog2.
package ct_pkg;

    typedef enum logic {
        S_SOP  = 1'b0,
        S_BODY = 1'b1
    } route_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/ct_skid.sv
// ct_skid: 2-entry FIFO register slice with a fully registered o_ready.
// Ports: i_data/i_valid/o_ready upstream, o_data/o_valid/i_ready downstream.
module ct_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic             push;
    logic             pop;

    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign o_valid = (count != 2'd0);
    assign o_data  = head;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    // o_ready is a register, so a push is never offered while count is 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= 2'd0;
            o_ready <= 1'b0;
        end else begin
            count   <= count_nxt;
            o_ready <= (count_nxt < 2'd2);
            if (pop) begin
                if (count == 2'd2)
                    head <= tail;
                else if (push)
                    head <= i_data;
            end else if (push) begin
                if (count == 2'd0)
                    head <= i_data;
                else
                    tail <= i_data;
            end
        end
    end

endmodule

// File: rtl/ct_route.sv
// ct_route: packet-aware 1-to-RADIX router with input skid buffer.
// Ports: clk, reset, i_data/i_valid/o_ready upstream,
//        o_data/o_valid/i_ready per port, o_drop pulse on discard.
module ct_route
    import ct_pkg::*;
#(
    parameter int RADIX    = 2,
    parameter int WIDTH    = 8,
    parameter int EOP_LOC  = 0,
    parameter int DEST_LOC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [RADIX*WIDTH-1:0] o_data,
    output logic [RADIX-1:0]       o_valid,
    input  logic [RADIX-1:0]       i_ready,
    output logic                   o_drop
);

    localparam int RADBITS = clog2(RADIX);
    localparam logic [RADBITS:0] RAD_LIM = (RADBITS + 1)'(RADIX);

    logic [WIDTH-1:0]   head;
    logic               head_valid;
    logic               consume;
    logic               eop;
    logic [RADBITS-1:0] dest;
    logic               oor;

    route_state_t       state;
    route_state_t       state_nxt;
    logic [RADBITS-1:0] sel;
    logic [RADBITS-1:0] sel_nxt;
    logic               drop_flag;
    logic               drop_flag_nxt;
    logic [RADBITS-1:0] route_idx;
    logic               drop_eff;

    ct_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (head),
        .o_valid (head_valid),
        .i_ready (consume)
    );

    assign eop    = head[EOP_LOC];
    assign dest   = head[DEST_LOC +: RADBITS];
    // Widened compare; constant-false when RADIX is a power of two.
    assign oor    = ({1'b0, dest} >= RAD_LIM);
    assign o_data = {RADIX{head}};

    always_comb begin
        route_idx = sel;
        drop_eff  = drop_flag;
        if (state == S_SOP) begin
            route_idx = dest;
            drop_eff  = oor;
        end
    end

    always_comb begin
        o_valid = '0;
        for (int k = 0; k < RADIX; k++)
            o_valid[k] = head_valid && !drop_eff &&
                         (route_idx == RADBITS'(k));
    end

    // Dropped beats drain without looking at any i_ready.
    assign consume = drop_eff ? head_valid : |(o_valid & i_ready);
    assign o_drop  = head_valid && (state == S_SOP) && oor;

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        drop_flag_nxt = drop_flag;
        unique case (state)
            S_SOP: begin
                if (consume) begin
                    if (!oor)
                        sel_nxt = dest;
                    if (!eop) begin
                        state_nxt     = S_BODY;
                        drop_flag_nxt = oor;
                    end
                end
            end
            S_BODY: begin
                if (consume && eop) begin
                    state_nxt     = S_SOP;
                    drop_flag_nxt = 1'b0;
                end
            end
            default: state_nxt = S_SOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SOP;
            sel       <= '0;
            drop_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            drop_flag <= drop_flag_nxt;
        end
    end

endmodule

// File: tb/tb_ct_route.sv
// tb_ct_route: scoreboard bench for ct_route (RADIX=3, WIDTH=8).
// Packet-level model predicts per-port beats and drop count.
module tb_ct_route;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_data = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [23:0] o_data;
    logic [2:0]  o_valid;
    logic [2:0]  i_ready = 3'b111;
    logic        o_drop;

    always #5 clk = ~clk;

    ct_route #(
        .RADIX    (3),
        .WIDTH    (8),
        .EOP_LOC  (0),
        .DEST_LOC (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_drop  (o_drop)
    );

    int tests = 0;
    int fails = 0;
    int acc_cnt = 0;
    int drops_exp = 0;
    int drops_seen = 0;
    int cyc = 0;
    int rand_ready = 0;
    logic [7:0] sb_data[$];
    int         sb_port[$];
    int         dcyc[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready != 0)
            i_ready = 3'($urandom);
    end

    // Monitor: pops the scoreboard on every downstream handshake.
    logic        prev_stall = 1'b0;
    logic [2:0]  prev_v;
    logic [23:0] prev_d;
    always @(negedge clk) begin
        int port;
        cyc++;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if ($countones(o_valid) > 1)
                check("onehot", int'(o_valid), 0);
            if (prev_stall) begin
                check("stable_valid", int'(o_valid), int'(prev_v));
                check("stable_data", int'(o_data), int'(prev_d));
            end
            if (o_drop)
                drops_seen++;
            port = -1;
            for (int k = 0; k < 3; k++)
                if (o_valid[k]) port = k;
            prev_stall = 1'b0;
            if (port >= 0) begin
                if (i_ready[port]) begin
                    if (sb_data.size() == 0) begin
                        check("unexpected_beat", port, -1);
                    end else begin
                        check("port", port, sb_port.pop_front());
                        check("data", int'(o_data[port*8 +: 8]),
                              int'(sb_data.pop_front()));
                        dcyc.push_back(cyc);
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_v = o_valid;
                    prev_d = o_data;
                end
            end
        end
    end

    task automatic expect_beat(input int port, input logic [7:0] b);
        sb_port.push_back(port);
        sb_data.push_back(b);
    endtask

    // Call at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [7:0] b);
        logic r;
        int n;
        i_data = b;
        i_valid = 1'b1;
        n = 0;
        forever begin
            r = o_ready;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 2000) begin
                $display("FAIL send_timeout: got stalled expected accept");
                $fatal(1);
            end
        end
        i_valid = 1'b0;
        acc_cnt++;
    endtask

    task automatic send_pkt(input int dest, input int len, input int gap);
        logic [7:0] b[$];
        int p;
        int df;
        for (int i = 0; i < len; i++) begin
            p = int'($urandom);
            df = (i == 0) ? dest : int'($urandom_range(0, 3));
            b.push_back({p[4:0], df[1:0], (i == len - 1)});
        end
        if (dest < 3) begin
            foreach (b[i]) expect_beat(dest, b[i]);
        end else begin
            drops_exp++;
        end
        foreach (b[i]) begin
            send_beat(b[i]);
            if (gap != 0 && $urandom_range(0, 3) == 0)
                @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_data.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_data.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int acc0;
        int d0;
        repeat (2) @(negedge clk);
        check("rst_o_ready", int'(o_ready), 0);
        check("rst_o_valid", int'(o_valid), 0);
        check("rst_o_drop", int'(o_drop), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(o_ready), 1);

        // Back-to-back single-beat packets to three ports.
        dcyc.delete();
        expect_beat(1, 8'h03);
        expect_beat(2, 8'h05);
        expect_beat(0, 8'h01);
        send_beat(8'h03);
        send_beat(8'h05);
        send_beat(8'h01);
        wait_drain();
        check("n_deliv", dcyc.size(), 3);
        if (dcyc.size() == 3) begin
            check("gap01", dcyc[1] - dcyc[0], 1);
            check("gap12", dcyc[2] - dcyc[1], 1);
        end

        // Backpressure: selected port held low, upstream keeps pushing.
        i_ready = 3'b000;
        acc0 = acc_cnt;
        fork
            send_pkt(2, 6, 0);
        join_none
        repeat (8) @(negedge clk);
        check("bp_accepted", acc_cnt - acc0, 2);
        check("bp_o_ready", int'(o_ready), 0);
        i_ready = 3'b111;
        wait fork;
        wait_drain();

        // Drop of an out-of-range packet, then a normal one.
        d0 = drops_seen;
        send_pkt(3, 3, 0);
        send_pkt(0, 2, 0);
        wait_drain();
        check("drop_pulses", drops_seen - d0, 1);

        // Isolation: packet to port 1, only port 0 ready.
        i_ready = 3'b001;
        fork
            send_pkt(1, 2, 0);
        join_none
        repeat (6) @(negedge clk);
        check("iso_valid", int'(o_valid), 3'b010);
        check("iso_pending", sb_data.size(), 2);
        i_ready = 3'b111;
        wait fork;
        wait_drain();

        // Random traffic with random downstream readiness.
        rand_ready = 1;
        for (int n = 0; n < 60; n++)
            send_pkt(int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 4)), 1);
        wait_drain();
        rand_ready = 0;
        @(negedge clk);
        i_ready = 3'b111;
        check("drop_total", drops_seen, drops_exp);

        // Reset in the middle of a buffered packet.
        i_ready = 3'b000;
        send_beat({5'h0a, 2'd1, 1'b0});
        send_beat({5'h0b, 2'd2, 1'b0});
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_ready", int'(o_ready), 0);
        check("mid_rst_drop", int'(o_drop), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        i_ready = 3'b111;
        expect_beat(1, 8'h03);
        send_beat(8'h03);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
